ram8_arbiter: RTL and testbench
===============================

# ram8_arbiter

Sequencer and two-port arbiter for the 8-word × 32-bit register-file RAM (`ram8`). After reset it zero-fills all eight words, then shares the single RAM port between two requesters, A (instruction side) and B (data side), with round-robin priority. Each access is a req/ack transaction, and read data is registered. It sits between the CPU front-end/LSU and the `ram8` instance, and is the only driver of the RAM's control inputs.

## Interface
- No parameters. Data width is fixed at 32, address width at 3, depth at 8.
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `req_a`, `req_b` input 1: request from requester A or B. Held high until the matching ack.
- `we_a`, `we_b` input 1: 1 = write, 0 = read. Held stable with req.
- `addr_a`, `addr_b` input 3: word address. Held stable with req.
- `wdata_a`, `wdata_b` input 32: write data. Held stable with req.
- `ack_a`, `ack_b` output 1: one-cycle completion pulse.
- `rdata` output 32: registered read data. Valid in the ack cycle and held until the next read completes.
- `ready` output 1: high once the zero-fill is complete.
- `ram_en` output 1: RAM enable.
- `ram_read` output 1: 1 = read, 0 = write.
- `ram_addr` output 3: RAM word address.
- `ram_in` output 32: RAM write data.
- `ram_out` input 32: RAM read data. Combinational, valid in the same cycle as `ram_en`=1 and `ram_read`=1.

## Operation
RAM contract:
- `ram_en`=1, `ram_read`=0: `ram_in` is written to `ram_addr` at the clock edge.
- `ram_en`=1, `ram_read`=1: `ram_out` presents the word at `ram_addr` in the same cycle.

State machine: CLEAR, IDLE, ACCESS, RESP. Registers: 3-bit clear counter `cnt`, priority pointer `prio` (0 = A first), and latched `sel`, `we_l`, `addr_l`, `wdata_l`.

- **CLEAR**
  - Drives `ram_en`=1, `ram_read`=0, `ram_addr`=`cnt`, `ram_in`=0.
  - `cnt`+1 each cycle.
  - When `cnt`==7, goes to IDLE and sets `ready`=1. `ready` stays 1 until the next reset.
  - Requests are ignored. They stay pending until IDLE.
- **IDLE**
  - Drives `ram_en`=0.
  - If neither request is high, stays in IDLE.
  - If only one request is high, that requester wins.
  - If both are high, the side named by `prio` wins.
  - On a win, latches the winner's `we`/`addr`/`wdata` into `we_l`/`addr_l`/`wdata_l`, records the winner in `sel`, and goes to ACCESS.
- **ACCESS**
  - Drives `ram_en`=1, `ram_read`=~`we_l`, `ram_addr`=`addr_l`.
  - `ram_in`=`wdata_l` on a write, 0 on a read.
  - On a read, `rdata` <= `ram_out` at the edge.
  - Goes to RESP.
- **RESP**
  - Drives `ram_en`=0.
  - Asserts `ack_a` (`sel`=A) or `ack_b` (`sel`=B) for exactly one cycle.
  - Sets `prio` to the side not served.
  - Goes to IDLE.

Read and write rules:
- `rdata` is unchanged by write transactions.
- `ram_in`=0 and `ram_addr`=0 whenever `ram_en`=0, except in CLEAR.

Requester handshake:
- Keep req and operands stable from assertion through the ack cycle.
- Deassert req, or present a new request, in the cycle after ack.
- A req still high in the cycle after ack counts as a new request.

## Timing
- Reset values, and values while `rst`=1 regardless of state:
  - `ram_en`=0 (forced combinationally, so no write commits during reset).
  - `ack_a`=`ack_b`=0, `rdata`=0, `ready`=0.
  - `ram_read`=0, `ram_addr`=0, `ram_in`=0.
  - `cnt`=0, `prio`=0.
  - State = CLEAR on the first edge with `rst` low afterwards.
- Zero-fill takes 8 cycles. `ready` rises on the edge ending the 8th CLEAR cycle.
- Transaction latency: req sampled high in IDLE at cycle T, RAM accessed in cycle T+1, ack and `rdata` valid in cycle T+2.
- Throughput is one transaction per 3 cycles. With both requesters continuously active, grants alternate A, B, A, B, ...
- Reset mid-transaction (ACCESS or RESP):
  - The transaction is aborted with no ack, and any in-flight write does not commit.
  - CLEAR restarts from `cnt`=0.
  - `prio` returns to A.
- `ack_a` and `ack_b` are never high in the same cycle.
- At most one RAM access occurs per transaction.

## Test plan
- **Reset and clear:**
  - Hold `rst` for 2 cycles, then release.
  - `ready` must be 0 for exactly 8 cycles, then 1.
  - `ram_en`=1 with `ram_read`=0 and `ram_addr` 0..7 in order.
  - A read of any address afterwards returns 0x00000000.
- **Write then read, A only:**
  - A writes 0xDEADBEEF to address 5, then reads address 5.
  - Each `ack_a` arrives 2 cycles after req is sampled.
  - The read's `rdata` = 0xDEADBEEF.
  - `rdata` is unchanged across the write's ack.
- **Simultaneous requests:**
  - After reset, A reads address 1 and B reads address 2, both asserted in the same cycle and held.
  - `ack_a` comes first, then `ack_b` 3 cycles later.
- **Continuous contention:**
  - Both reqs are re-asserted after every ack for 6 transactions.
  - Ack order must be A, B, A, B, A, B, with one ack every 3 cycles.
- **Request during clear:**
  - B writes 0x12345678 to address 7, asserted in cycle 2 of CLEAR.
  - No `ack_b` before `ready`.
  - Ack arrives 2 cycles after the first IDLE.
  - A read of address 7 returns 0x12345678, so the clear did not overwrite it.
- **Reset mid-write:**
  - A writes 0xA5A5A5A5 to address 3, and `rst` is asserted in the ACCESS cycle.
  - No ack, and `ram_en`=0 during reset.
  - After the re-clear, address 3 reads 0x00000000.

Source files
------------

// File: rtl/ram8_arbiter.sv
// Zero-fill sequencer and round-robin two-port arbiter for the 8x32 ram8 register file.
// Requester A is the instruction side, B the data side; each access is a req/ack transaction.
module ram8_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic        req_b,
    input  logic        we_a,
    input  logic        we_b,
    input  logic [2:0]  addr_a,
    input  logic [2:0]  addr_b,
    input  logic [31:0] wdata_a,
    input  logic [31:0] wdata_b,
    output logic        ack_a,
    output logic        ack_b,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        ram_en,
    output logic        ram_read,
    output logic [2:0]  ram_addr,
    output logic [31:0] ram_in,
    input  logic [31:0] ram_out
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 3;

    typedef enum logic [1:0] {
        S_CLEAR  = 2'd0,
        S_IDLE   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t        state;
    logic [AW-1:0] cnt;
    logic          prio;
    logic          sel;
    logic          we_l;
    logic [AW-1:0] addr_l;
    logic [DW-1:0] wdata_l;
    logic          pick_b_c;

    // B wins when it is the only requester, or when both request and B holds priority
    assign pick_b_c = req_b && (!req_a || prio);

    // Sequencer, arbitration and registered responses
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_CLEAR;
            cnt     <= '0;
            prio    <= 1'b0;
            sel     <= 1'b0;
            we_l    <= 1'b0;
            addr_l  <= '0;
            wdata_l <= '0;
            ack_a   <= 1'b0;
            ack_b   <= 1'b0;
            rdata   <= '0;
            ready   <= 1'b0;
        end else begin
            ack_a <= 1'b0;
            ack_b <= 1'b0;
            case (state)
                S_CLEAR: begin
                    cnt <= cnt + AW'(1);
                    if (cnt == AW'(7)) begin
                        state <= S_IDLE;
                        ready <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (req_a || req_b) begin
                        sel     <= pick_b_c;
                        we_l    <= pick_b_c ? we_b    : we_a;
                        addr_l  <= pick_b_c ? addr_b  : addr_a;
                        wdata_l <= pick_b_c ? wdata_b : wdata_a;
                        state   <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!we_l) begin
                        rdata <= ram_out;
                    end
                    ack_a <= ~sel;
                    ack_b <= sel;
                    state <= S_RESP;
                end
                S_RESP: begin
                    prio  <= ~sel;
                    state <= S_IDLE;
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

    // RAM port decode; reset forces the port idle so nothing commits while rst is high
    always_comb begin
        ram_en   = 1'b0;
        ram_read = 1'b0;
        ram_addr = '0;
        ram_in   = '0;
        if (!rst) begin
            case (state)
                S_CLEAR: begin
                    ram_en   = 1'b1;
                    ram_addr = cnt;
                end
                S_ACCESS: begin
                    ram_en   = 1'b1;
                    ram_read = ~we_l;
                    ram_addr = addr_l;
                    ram_in   = we_l ? wdata_l : DW'(0);
                end
                default: ram_en = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_ram8_arbiter.sv
// Scoreboard bench for ram8_arbiter with a behavioural ram8 model on the RAM port.
// Stimulus pushes expected acks (side, cycle, rdata); a negedge monitor pops and compares.
module tb_ram8_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic        we_a = 1'b0, we_b = 1'b0;
    logic [2:0]  addr_a = 3'd0, addr_b = 3'd0;
    logic [31:0] wdata_a = 32'd0, wdata_b = 32'd0;
    logic        ack_a, ack_b, ready;
    logic [31:0] rdata;
    logic        ram_en, ram_read;
    logic [2:0]  ram_addr;
    logic [31:0] ram_in, ram_out;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        logic        side;
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    logic [31:0] mem [8];
    logic        mem_init = 1'b0;

    ram8_arbiter dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b),
        .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b),
        .wdata_a(wdata_a), .wdata_b(wdata_b),
        .ack_a(ack_a), .ack_b(ack_b),
        .rdata(rdata), .ready(ready),
        .ram_en(ram_en), .ram_read(ram_read),
        .ram_addr(ram_addr), .ram_in(ram_in),
        .ram_out(ram_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ram8 model: combinational read, write at the edge; starts with non-zero junk
    assign ram_out = mem[ram_addr];
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 8; i++) mem[i] <= 32'hBAD0_0000 + 32'(i);
            mem_init <= 1'b1;
        end else if (ram_en && !ram_read) begin
            mem[ram_addr] <= ram_in;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ack(input logic side, input logic [31:0] data, input int at);
        exp_q.push_back('{side, data, at});
    endtask

    // Monitor: every ack is matched against the oldest expectation
    always @(negedge clk) begin
        if (ack_a || ack_b) begin
            chk("ack_exclusive", 32'(ack_a && ack_b), 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_ack: ack_a=%b ack_b=%b at cycle %0d, none expected",
                         ack_a, ack_b, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ack_side", 32'(ack_b), 32'(mon_e.side));
                chk("ack_cycle", 32'(cyc), 32'(mon_e.at));
                chk("ack_rdata", rdata, mon_e.data);
            end
        end
    end

    task automatic do_reset(input bit b_early);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_acks", 32'({ack_a, ack_b}), 32'd0);
        tick();
        req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
        addr_a = 3'd0; addr_b = 3'd0; wdata_a = 32'd0; wdata_b = 32'd0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (b_early && i == 1) begin
                req_b = 1'b1; we_b = 1'b1; addr_b = 3'd7; wdata_b = 32'h1234_5678;
                expect_ack(1'b1, 32'h0, cyc + 9);
            end
            @(negedge clk);
            chk("clear_ready", 32'(ready), 32'd0);
            chk("clear_ram_en", 32'(ram_en), 32'd1);
            chk("clear_ram_read", 32'(ram_read), 32'd0);
            chk("clear_ram_addr", 32'(ram_addr), 32'(i));
            chk("clear_ram_in", ram_in, 32'd0);
            tick();
        end
        @(negedge clk);
        chk("ready_up", 32'(ready), 32'd1);
        chk("idle_ram_en", 32'(ram_en), 32'd0);
        chk("reset_rdata", rdata, 32'd0);
    endtask

    // One transaction from an idle arbiter; returns in the cycle after the ack
    task automatic single(input logic side, input logic we, input logic [2:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata);
        if (side) begin
            req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wdata;
        end else begin
            req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wdata;
        end
        expect_ack(side, exp_rdata, cyc + 2);
        tick(); tick(); tick();
        if (side) req_b = 1'b0;
        else req_a = 1'b0;
    endtask

    // Both sides read in the same cycle; A must win after reset-level priority
    task automatic both_read(input logic [2:0] aa, input logic [2:0] ab,
                             input logic [31:0] da, input logic [31:0] db);
        req_a = 1'b1; we_a = 1'b0; addr_a = aa;
        req_b = 1'b1; we_b = 1'b0; addr_b = ab;
        expect_ack(1'b0, da, cyc + 2);
        expect_ack(1'b1, db, cyc + 5);
        tick(); tick(); tick();
        req_a = 1'b0;
        tick(); tick(); tick();
        req_b = 1'b0;
    endtask

    initial begin
        // Reset and zero-fill, then reads of cleared words
        do_reset(1'b0);
        single(1'b0, 1'b0, 3'd0, 32'd0, 32'h0);
        single(1'b1, 1'b0, 3'd7, 32'd0, 32'h0);

        // A write/read, then a write from B that must leave rdata alone
        single(1'b0, 1'b1, 3'd5, 32'hDEAD_BEEF, 32'h0);
        single(1'b0, 1'b0, 3'd5, 32'd0, 32'hDEAD_BEEF);
        single(1'b1, 1'b1, 3'd6, 32'h00C0_FFEE, 32'hDEAD_BEEF);
        single(1'b1, 1'b0, 3'd6, 32'd0, 32'h00C0_FFEE);

        // Simultaneous requests straight after reset
        do_reset(1'b0);
        both_read(3'd1, 3'd2, 32'h0, 32'h0);

        // Continuous contention: A w4, w6, r4 against B r4, r6, w2
        req_a = 1'b1; we_a = 1'b1; addr_a = 3'd4; wdata_a = 32'hCAFE_0001;
        req_b = 1'b1; we_b = 1'b0; addr_b = 3'd4; wdata_b = 32'd0;
        expect_ack(1'b0, 32'h0,         cyc + 2);
        expect_ack(1'b1, 32'hCAFE_0001, cyc + 5);
        expect_ack(1'b0, 32'hCAFE_0001, cyc + 8);
        expect_ack(1'b1, 32'hCAFE_0002, cyc + 11);
        expect_ack(1'b0, 32'hCAFE_0001, cyc + 14);
        expect_ack(1'b1, 32'hCAFE_0001, cyc + 17);
        tick(); tick(); tick();
        addr_a = 3'd6; wdata_a = 32'hCAFE_0002;
        tick(); tick(); tick();
        addr_b = 3'd6;
        tick(); tick(); tick();
        we_a = 1'b0; addr_a = 3'd4; wdata_a = 32'd0;
        tick(); tick(); tick();
        we_b = 1'b1; addr_b = 3'd2; wdata_b = 32'h0BAD_F00D;
        tick(); tick(); tick();
        req_a = 1'b0;
        tick(); tick(); tick();
        req_b = 1'b0;

        // B write issued during the zero-fill must survive it
        do_reset(1'b1);
        tick(); tick(); tick();
        req_b = 1'b0;
        single(1'b0, 1'b0, 3'd7, 32'd0, 32'h1234_5678);

        // Reset in the ACCESS cycle of a write: aborted, no commit, priority back to A
        req_a = 1'b1; we_a = 1'b1; addr_a = 3'd3; wdata_a = 32'hA5A5_A5A5;
        tick();
        do_reset(1'b0);
        both_read(3'd3, 3'd7, 32'h0, 32'h0);

        tick(); tick(); tick(); tick();
        chk("pending_acks", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
